// File: rtl/l2_ram_banked_init_pkg.sv
// ---------------------------------------------------------------------------
// l2_ram_pkg
// Shared types and helpers for the banked L2 RAM with hardware zero-fill.
//   init_state_e : sequencer state (INIT = zero-fill running, READY = serving)
//   BYTE_W       : bits per byte lane
//   nb_bytes()   : number of byte lanes for a given data width
// ---------------------------------------------------------------------------
package l2_ram_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int unsigned BYTE_W = 32'd8;

    function automatic int unsigned nb_bytes(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/l2_ram_banked_init_sram.sv
// ---------------------------------------------------------------------------
// l2_bank_sram
// Single-port behavioural SRAM bank with byte enables. Reads return the word
// as it was before any write in the same cycle. The response pipeline is one
// register (READ_LAT=1) or two (READ_LAT=2).
// Ports:
//   clk_i, rst_ni     clock, async active-low reset (response pipe only)
//   req_i, we_i       access strobe and write select
//   resp_i            1: this access produces an rvalid response
//                     (0 for internal zero-fill writes)
//   be_i              byte enables
//   addr_i, wdata_i   word address and write data
//   rvalid_o, rdata_o response strobe and data (0 when no read response)
// ---------------------------------------------------------------------------
module l2_bank_sram
    import l2_ram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32'd14,
    parameter int unsigned DATA_W   = 32'd32,
    parameter int unsigned READ_LAT = 32'd1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    input  logic                       we_i,
    input  logic                       resp_i,
    input  logic [DATA_W/BYTE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic                       rvalid_o,
    output logic [DATA_W-1:0]          rdata_o
);

    localparam int unsigned NBYTES = nb_bytes(DATA_W);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] wr_word_d;
    logic              rvalid_d, rvalid_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;

    // merge enabled write bytes into the currently stored word
    always_comb begin
        wr_word_d = mem_q[addr_i];
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (be_i[i]) begin
                wr_word_d[i*BYTE_W +: BYTE_W] = wdata_i[i*BYTE_W +: BYTE_W];
            end else begin
                wr_word_d[i*BYTE_W +: BYTE_W] = mem_q[addr_i][i*BYTE_W +: BYTE_W];
            end
        end
    end

    // first response stage: read data sampled before this cycle's write lands
    always_comb begin
        rvalid_d = req_i & resp_i;
        if (rvalid_d && !we_i) begin
            rdata_d = mem_q[addr_i];
        end else begin
            rdata_d = '0;
        end
    end

    // storage array: contents intentionally survive reset
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            mem_q[addr_i] <= wr_word_d;
        end
    end

    // first response register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    if (READ_LAT == 32'd2) begin : g_lat2
        logic              rvalid2_q;
        logic [DATA_W-1:0] rdata2_q;

        // optional output register for the two-cycle latency build
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid2_q <= 1'b0;
                rdata2_q  <= '0;
            end else begin
                rvalid2_q <= rvalid_q;
                rdata2_q  <= rdata_q;
            end
        end

        assign rvalid_o = rvalid2_q;
        assign rdata_o  = rdata2_q;
    end else begin : g_lat1
        assign rvalid_o = rvalid_q;
        assign rdata_o  = rdata_q;
    end

endmodule

// File: rtl/l2_ram_banked_init.sv
// ---------------------------------------------------------------------------
// l2_ram_banked_init
// NB_BANKS_INTL interleaved + NB_BANKS_PRI private SRAM banks behind per-bank
// req/gnt/rvalid ports, with a zero-fill sequencer that runs after reset
// (unless test_mode_i) or while init_ni is sampled low in READY.
// Ports (NB = NB_BANKS_INTL + NB_BANKS_PRI, interleaved banks first):
//   clk_i, rst_ni      clock, async active-low reset
//   init_ni            active-low zero-fill request (level)
//   test_mode_i        1: skip zero-fill after reset
//   req_i/gnt_o        per-bank handshake, transfer on req_i & gnt_o
//   we_i, be_i, add_i, wdata_i   per-bank access fields
//   rvalid_o, rdata_o  per-bank response, READ_LAT cycles after transfer
//   init_busy_o        high while zero-fill runs
// ---------------------------------------------------------------------------
module l2_ram_banked_init
    import l2_ram_pkg::*;
#(
    parameter int unsigned NB_BANKS_INTL = 32'd4,
    parameter int unsigned NB_BANKS_PRI  = 32'd2,
    parameter int unsigned ADDR_W_INTL   = 32'd14,
    parameter int unsigned ADDR_W_PRI    = 32'd13,
    parameter int unsigned DATA_W        = 32'd32,
    parameter int unsigned READ_LAT      = 32'd1,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      init_ni,
    input  logic                      test_mode_i,
    input  logic                      req_i   [NB_BANKS_INTL+NB_BANKS_PRI-1:0],
    output logic                      gnt_o   [NB_BANKS_INTL+NB_BANKS_PRI-1:0],
    input  logic                      we_i    [NB_BANKS_INTL+NB_BANKS_PRI-1:0],
    input  logic [DATA_W/BYTE_W-1:0]  be_i    [NB_BANKS_INTL+NB_BANKS_PRI-1:0],
    input  logic [ADDR_W_INTL-1:0]    add_i   [NB_BANKS_INTL+NB_BANKS_PRI-1:0],
    input  logic [DATA_W-1:0]         wdata_i [NB_BANKS_INTL+NB_BANKS_PRI-1:0],
    output logic                      rvalid_o[NB_BANKS_INTL+NB_BANKS_PRI-1:0],
    output logic [DATA_W-1:0]         rdata_o [NB_BANKS_INTL+NB_BANKS_PRI-1:0],
    output logic                      init_busy_o
);

    localparam int unsigned NB     = NB_BANKS_INTL + NB_BANKS_PRI;
    localparam int unsigned NBYTES = nb_bytes(DATA_W);
    localparam logic [ADDR_W_INTL-1:0] CNT_LAST = '1;

    init_state_e            state_q, state_d;
    logic [ADDR_W_INTL-1:0] cnt_q, cnt_d;
    logic                   init_active_s;
    logic                   pri_init_en_s;
    logic                   ready_gnt_s;

    assign init_active_s = (state_q == INIT);
    assign init_busy_o   = init_active_s;
    // private banks are shallower: only the low part of the sweep touches them
    assign pri_init_en_s = ((cnt_q >> ADDR_W_PRI) == '0);
    // grant is withdrawn in the very cycle a zero-fill request is seen
    assign ready_gnt_s   = rst_ni & (state_q == READY) & init_ni;

    // sequencer next state: sweep every address once, then serve requests
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + ADDR_W_INTL'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = READY;
                end else begin
                    state_d = INIT;
                end
            end
            READY: begin
                cnt_d = '0;
                if (!init_ni) begin
                    state_d = INIT;
                end else begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = READY;
                cnt_d   = '0;
            end
        endcase
    end

    // sequencer state and sweep counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= (INIT_ON_RESET && !test_mode_i) ? INIT : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar b = 0; b < int'(NB); b++) begin : g_bank
        localparam bit          IS_PRI = (b >= int'(NB_BANKS_INTL));
        localparam int unsigned AW     = IS_PRI ? ADDR_W_PRI : ADDR_W_INTL;

        logic              req_s, we_s, resp_s;
        logic [NBYTES-1:0] be_s;
        logic [AW-1:0]     addr_s;
        logic [DATA_W-1:0] wdata_s;

        assign gnt_o[b] = ready_gnt_s;

        // bank port owner: zero-fill sweep during INIT, user port otherwise
        always_comb begin
            if (init_active_s) begin
                req_s   = IS_PRI ? pri_init_en_s : 1'b1;
                we_s    = 1'b1;
                resp_s  = 1'b0;
                be_s    = '1;
                addr_s  = cnt_q[AW-1:0];
                wdata_s = '0;
            end else begin
                req_s   = req_i[b] & ready_gnt_s;
                we_s    = we_i[b];
                resp_s  = 1'b1;
                be_s    = be_i[b];
                addr_s  = add_i[b][AW-1:0];  // private banks alias on upper bits
                wdata_s = wdata_i[b];
            end
        end

        l2_bank_sram #(
            .ADDR_W   (AW),
            .DATA_W   (DATA_W),
            .READ_LAT (READ_LAT)
        ) u_sram (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .req_i    (req_s),
            .we_i     (we_s),
            .resp_i   (resp_s),
            .be_i     (be_s),
            .addr_i   (addr_s),
            .wdata_i  (wdata_s),
            .rvalid_o (rvalid_o[b]),
            .rdata_o  (rdata_o[b])
        );
    end

endmodule
